// File: rtl/html_tokenizer.sv
// html_tokenizer: splits an HTML character stream into TEXT / OPEN / CLOSE / END
// tokens. Characters and tokens each move through a valid/ready handshake; a
// token stays frozen on the outputs until the consumer takes it. Tag names are
// lower-cased and truncated to NAME_MAX, while attributes and comments are
// discarded.
module html_tokenizer #(
  parameter int CHAR_W   = 8,
  parameter int NAME_MAX = 16,
  parameter int LEN_W    = 5
) (
  input  logic                       clock,
  input  logic                       state_enable,
  input  logic                       char_valid,
  input  logic [CHAR_W-1:0]          char,
  output logic                       char_ready,
  input  logic                       input_done,
  output logic                       token_valid,
  input  logic                       token_ready,
  output logic [1:0]                 token_type,
  output logic [NAME_MAX*CHAR_W-1:0] token_name,
  output logic [LEN_W-1:0]           token_len
);
  localparam int NAME_W = NAME_MAX * CHAR_W;

  localparam logic [1:0] TOK_TEXT  = 2'd0;
  localparam logic [1:0] TOK_OPEN  = 2'd1;
  localparam logic [1:0] TOK_CLOSE = 2'd2;
  localparam logic [1:0] TOK_END   = 2'd3;

  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(NAME_MAX);
  localparam logic [CHAR_W-1:0] CH_LT    = CHAR_W'(8'h3C);
  localparam logic [CHAR_W-1:0] CH_GT    = CHAR_W'(8'h3E);
  localparam logic [CHAR_W-1:0] CH_SLASH = CHAR_W'(8'h2F);
  localparam logic [CHAR_W-1:0] CH_BANG  = CHAR_W'(8'h21);

  typedef enum logic [2:0] {
    S_DATA, S_TAG_OPEN, S_TAG_NAME, S_ATTR_SKIP, S_COMMENT, S_EMIT, S_DONE
  } state_t;

  state_t                state, pend_state, next_state;
  logic [NAME_W-1:0]     name_q, next_name, name_app, emit_name;
  logic [LEN_W-1:0]      len_q, next_len, emit_len;
  logic                  close_q, next_close;
  logic                  emit;
  logic [1:0]            emit_type, tag_type;
  logic [CHAR_W-1:0]     app_char;
  logic                  accept, at_end;

  function automatic logic [CHAR_W-1:0] to_lower(input logic [CHAR_W-1:0] c);
    if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) return c + CHAR_W'(8'h20);
    return c;
  endfunction

  function automatic logic is_space(input logic [CHAR_W-1:0] c);
    return (c == CHAR_W'(8'h20)) || (c == CHAR_W'(8'h09)) ||
           (c == CHAR_W'(8'h0A)) || (c == CHAR_W'(8'h0D));
  endfunction

  // Decide the effect of this cycle's character or end-of-input condition.
  always_comb begin
    accept     = char_valid & char_ready;
    at_end     = input_done & ~char_valid;
    app_char   = (state == S_DATA) ? char : to_lower(char);
    name_app   = name_q | (NAME_W'(app_char) << (len_q * CHAR_W));
    tag_type   = close_q ? TOK_CLOSE : TOK_OPEN;
    emit       = 1'b0;
    emit_type  = TOK_TEXT;
    emit_name  = name_q;
    emit_len   = len_q;
    next_state = state;
    next_name  = name_q;
    next_len   = len_q;
    next_close = close_q;
    if (state != S_EMIT && state != S_DONE) begin
      if (accept) begin
        case (state)
          S_DATA: begin
            if (char == CH_LT) begin
              next_state = S_TAG_OPEN;
              emit       = (len_q != '0);
            end else if (len_q == LEN_FULL - 1'b1) begin
              // Chunk is full: flush it so long text never drops characters.
              emit      = 1'b1;
              emit_name = name_app;
              emit_len  = LEN_FULL;
            end else begin
              next_name = name_app;
              next_len  = len_q + 1'b1;
            end
          end
          S_TAG_OPEN: begin
            if (char == CH_SLASH) begin
              next_close = 1'b1;
              next_state = S_TAG_NAME;
            end else if (char == CH_BANG) begin
              next_state = S_COMMENT;
            end else if (char == CH_GT) begin
              next_state = S_DATA;
            end else begin
              next_name  = name_app;
              next_len   = len_q + 1'b1;
              next_state = S_TAG_NAME;
            end
          end
          S_TAG_NAME, S_ATTR_SKIP: begin
            if (char == CH_GT) begin
              emit       = 1'b1;
              emit_type  = tag_type;
              next_close = 1'b0;
              next_state = S_DATA;
            end else if (state == S_TAG_NAME) begin
              if (is_space(char) || char == CH_SLASH) begin
                next_state = S_ATTR_SKIP;
              end else if (len_q < LEN_FULL) begin
                next_name = name_app;
                next_len  = len_q + 1'b1;
              end
            end
          end
          S_COMMENT: begin
            if (char == CH_GT) next_state = S_DATA;
          end
          default: ;
        endcase
      end else if (at_end) begin
        emit = 1'b1;
        if (state == S_DATA && len_q != '0) begin
          emit_type  = TOK_TEXT;
          next_state = S_DATA;
        end else begin
          // Any partial tag or comment is abandoned; only END goes out.
          emit_type  = TOK_END;
          emit_name  = '0;
          emit_len   = '0;
          next_name  = '0;
          next_len   = '0;
          next_close = 1'b0;
          next_state = S_DONE;
        end
      end
    end
  end

  // Tokenizer FSM with registered handshake outputs and the held token.
  always_ff @(posedge clock or negedge state_enable) begin
    if (!state_enable) begin
      state       <= S_DATA;
      pend_state  <= S_DATA;
      name_q      <= '0;
      len_q       <= '0;
      close_q     <= 1'b0;
      char_ready  <= 1'b0;
      token_valid <= 1'b0;
      token_type  <= TOK_TEXT;
      token_name  <= '0;
      token_len   <= '0;
    end else begin
      case (state)
        S_EMIT: begin
          if (token_ready) begin
            token_valid <= 1'b0;
            name_q      <= '0;
            len_q       <= '0;
            state       <= pend_state;
            char_ready  <= (pend_state != S_DONE);
          end
        end
        S_DONE: begin
          char_ready  <= 1'b0;
          token_valid <= 1'b0;
        end
        default: begin
          name_q     <= next_name;
          len_q      <= next_len;
          close_q    <= next_close;
          char_ready <= ~emit;
          if (emit) begin
            state       <= S_EMIT;
            pend_state  <= next_state;
            token_valid <= 1'b1;
            token_type  <= emit_type;
            token_name  <= emit_name;
            token_len   <= emit_len;
          end else begin
            state <= next_state;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_html_tokenizer.sv
// tb_html_tokenizer: directed scenarios plus randomized streams for
// html_tokenizer, checked against a string-level reference tokenizer.
`timescale 1ns/1ps
module tb_html_tokenizer;
  localparam int NAME_W = 128;

  logic              clock = 1'b0;
  logic              state_enable = 1'b1;
  logic              char_valid = 1'b0;
  logic [7:0]        char = 8'h00;
  logic              input_done = 1'b0;
  logic              token_ready = 1'b0;
  logic              char_ready, token_valid;
  logic [1:0]        token_type;
  logic [NAME_W-1:0] token_name;
  logic [4:0]        token_len;

  typedef struct packed {
    logic [1:0]        t;
    logic [NAME_W-1:0] name;
    logic [4:0]        len;
  } tok_t;

  tok_t got_q[$];
  tok_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  html_tokenizer #(.CHAR_W(8), .NAME_MAX(16), .LEN_W(5)) dut (
    .clock(clock), .state_enable(state_enable),
    .char_valid(char_valid), .char(char), .char_ready(char_ready),
    .input_done(input_done),
    .token_valid(token_valid), .token_ready(token_ready),
    .token_type(token_type), .token_name(token_name), .token_len(token_len)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic tok_t mk(input logic [1:0] t, input logic [NAME_W-1:0] n, input int l);
    tok_t r;
    r.t = t; r.name = n; r.len = 5'(l);
    return r;
  endfunction

  function automatic logic [7:0] lc(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

  // Reference tokenizer: works on the whole string, locating each tag by
  // searching for its closing '>' and classifying the body in one pass.
  task automatic model(input string s, input bit done);
    logic [NAME_W-1:0] txt, nm;
    int tl, nl, i, j, k, b;
    bit close, first;
    logic [7:0] c;
    exp_q.delete();
    txt = '0; tl = 0; i = 0;
    while (i < s.len()) begin
      if (s[i] != 8'h3C) begin
        txt[tl*8 +: 8] = s[i];
        tl++;
        if (tl == 16) begin exp_q.push_back(mk(2'd0, txt, 16)); txt = '0; tl = 0; end
        i++;
      end else begin
        if (tl > 0) begin exp_q.push_back(mk(2'd0, txt, tl)); txt = '0; tl = 0; end
        j = i + 1;
        while (j < s.len() && s[j] != 8'h3E) j++;
        if (j >= s.len()) begin
          i = s.len();
        end else begin
          b = i + 1;
          if (j > b && s[b] != 8'h21) begin
            close = (s[b] == 8'h2F);
            k = close ? b + 1 : b;
            first = !close;
            nm = '0; nl = 0;
            while (k < j) begin
              c = s[k];
              if (!first && (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h2F)) break;
              first = 1'b0;
              if (nl < 16) begin nm[nl*8 +: 8] = lc(c); nl++; end
              k++;
            end
            exp_q.push_back(mk(close ? 2'd2 : 2'd1, nm, nl));
          end
          i = j + 1;
        end
      end
    end
    if (done) begin
      if (tl > 0) exp_q.push_back(mk(2'd0, txt, tl));
      exp_q.push_back(mk(2'd3, '0, 0));
    end
  endtask

  task automatic do_reset();
    state_enable = 1'b0; char_valid = 1'b0; input_done = 1'b0; token_ready = 1'b0;
    @(posedge clock); #1;
    state_enable = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    int w = 0;
    char = c; char_valid = 1'b1;
    while (!char_ready && w < 50) begin @(posedge clock); #1; w++; end
    @(posedge clock); #1;
    char_valid = 1'b0;
    n_total++;
    if (w >= 50) $display("FAIL send_char timeout: char_ready=%0d, required 1", char_ready);
    else n_pass++;
  endtask

  // Drive a stream with random gaps and back-pressure, collect tokens and
  // compare them with exp_q.
  task automatic run_stream(input string label, input string s, input bit done,
                            input int vpct, input int rpct);
    int idx = 0, cyc = 0, idle = 0, stab_err = 0, ovl_err = 0, after_err = 0;
    bit fin = 0, holding = 0, acc;
    logic [134:0] held = '0;
    got_q.delete();
    while (!fin && cyc < 3000) begin
      if (holding && (!token_valid || {token_type, token_name, token_len} !== held)) stab_err++;
      if (char_ready && token_valid) ovl_err++;
      char_valid  = (idx < s.len()) && ($urandom_range(99) < vpct);
      char        = (idx < s.len()) ? s[idx] : 8'h00;
      input_done  = done && (idx >= s.len());
      token_ready = (!done && idx >= s.len()) ? 1'b1 : ($urandom_range(99) < rpct);
      holding = token_valid && !token_ready;
      held    = {token_type, token_name, token_len};
      if (token_valid && token_ready) begin
        got_q.push_back(mk(token_type, token_name, int'(token_len)));
        if (token_type == 2'd3) fin = 1'b1;
      end
      if (!done && idx >= s.len()) begin idle++; if (idle > 30) fin = 1'b1; end
      acc = char_valid && char_ready;
      @(posedge clock); #1;
      if (acc) idx++;
      cyc++;
    end
    char_valid = 1'b0; token_ready = 1'b0;
    if (done) begin
      n_total++;
      if (!fin) $display("FAIL %s end token: not seen within %0d cycles", label, cyc);
      else n_pass++;
      char_valid = 1'b1; char = 8'h61; token_ready = 1'b1;
      repeat (4) begin
        if (char_ready || token_valid) after_err++;
        @(posedge clock); #1;
      end
      char_valid = 1'b0; token_ready = 1'b0;
      n_total++;
      if (after_err !== 0) $display("FAIL %s done state: %0d active cycles, required 0", label, after_err);
      else n_pass++;
    end
    input_done = 1'b0;
    n_total++;
    if (idx !== s.len()) $display("FAIL %s chars accepted: got %0d, want %0d", label, idx, s.len());
    else n_pass++;
    n_total++;
    if (stab_err !== 0) $display("FAIL %s held token changed: %0d times, required 0", label, stab_err);
    else n_pass++;
    n_total++;
    if (ovl_err !== 0) $display("FAIL %s char_ready with token_valid: %0d cycles, required 0", label, ovl_err);
    else n_pass++;
    n_total++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s token count: got %0d, want %0d", label, got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_total++;
      if (got_q[k] !== exp_q[k])
        $display("FAIL %s tok%0d: got type=%0d len=%0d name=%h, want type=%0d len=%0d name=%h",
                 label, k, got_q[k].t, got_q[k].len, got_q[k].name,
                 exp_q[k].t, exp_q[k].len, exp_q[k].name);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #2 state_enable = 1'b0;
    #1;
    n_total++; if (token_valid !== 1'b0) $display("FAIL reset token_valid: got %b, want 0", token_valid); else n_pass++;
    n_total++; if (token_type !== 2'd0) $display("FAIL reset token_type: got %0d, want 0", token_type); else n_pass++;
    n_total++; if (token_name !== '0) $display("FAIL reset token_name: got %h, want 0", token_name); else n_pass++;
    n_total++; if (token_len !== 5'd0) $display("FAIL reset token_len: got %0d, want 0", token_len); else n_pass++;
    n_total++; if (char_ready !== 1'b0) $display("FAIL reset char_ready: got %b, want 0", char_ready); else n_pass++;
    @(negedge clock);
    state_enable = 1'b1;
    #1;
    n_total++; if (char_ready !== 1'b0) $display("FAIL release char_ready early: got %b, want 0", char_ready); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (char_ready !== 1'b1) $display("FAIL release char_ready: got %b, want 1", char_ready); else n_pass++;
  endtask

  task automatic test_open_latency();
    string s = "<HTML";
    do_reset();
    token_ready = 1'b1;
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    send_char(8'h3E);
    n_total++; if (token_valid !== 1'b1) $display("FAIL open latency token_valid: got %b, want 1", token_valid); else n_pass++;
    n_total++; if (token_type !== 2'd1) $display("FAIL open type: got %0d, want 1", token_type); else n_pass++;
    n_total++; if (token_name !== 128'h6C6D7468) $display("FAIL open name: got %h, want 6c6d7468", token_name); else n_pass++;
    n_total++; if (token_len !== 5'd4) $display("FAIL open len: got %0d, want 4", token_len); else n_pass++;
    @(posedge clock); #1;
    token_ready = 1'b0;
    n_total++; if (token_valid !== 1'b0) $display("FAIL open taken token_valid: got %b, want 0", token_valid); else n_pass++;
    n_total++; if (char_ready !== 1'b1) $display("FAIL open char_ready return: got %b, want 1", char_ready); else n_pass++;
  endtask

  task automatic test_text_close_end();
    do_reset();
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 128'h6261, 2));
    exp_q.push_back(mk(2'd2, 128'h70, 1));
    exp_q.push_back(mk(2'd3, '0, 0));
    run_stream("text_close_end", "ab</p>", 1'b1, 100, 100);
  endtask

  task automatic test_backpressure();
    string s = "<a href=x>";
    do_reset();
    token_ready = 1'b0;
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    char = 8'h71; char_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (token_valid !== 1'b1 || token_type !== 2'd1 || token_name !== 128'h61 ||
          token_len !== 5'd1 || char_ready !== 1'b0)
        $display("FAIL backpressure hold c%0d: got v=%b t=%0d n=%h l=%0d cr=%b, want v=1 t=1 n=61 l=1 cr=0",
                 c, token_valid, token_type, token_name, token_len, char_ready);
      else n_pass++;
      @(posedge clock); #1;
    end
    token_ready = 1'b1;
    @(posedge clock); #1;
    char_valid = 1'b0; token_ready = 1'b0;
    n_total++; if (token_valid !== 1'b0) $display("FAIL backpressure taken: got %b, want 0", token_valid); else n_pass++;
    exp_q.delete();
    exp_q.push_back(mk(2'd3, '0, 0));
    run_stream("backpressure_end", "", 1'b1, 100, 100);
  endtask

  task automatic test_long_text();
    string s = "";
    do_reset();
    for (int i = 0; i < 20; i++) s = $sformatf("%sx", s);
    s = $sformatf("%s<", s);
    exp_q.delete();
    exp_q.push_back(mk(2'd0, {16{8'h78}}, 16));
    exp_q.push_back(mk(2'd0, 128'h78787878, 4));
    run_stream("long_text", s, 1'b0, 100, 100);
  endtask

  task automatic test_comment_empty();
    do_reset();
    exp_q.delete();
    exp_q.push_back(mk(2'd0, 128'h7A, 1));
    exp_q.push_back(mk(2'd3, '0, 0));
    run_stream("comment_empty", "<!-- c --><>z", 1'b1, 100, 100);
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete();
    exp_q.push_back(mk(2'd1, 128'h69, 1));
    exp_q.push_back(mk(2'd2, 128'h69, 1));
    exp_q.push_back(mk(2'd0, 128'h6948, 2));
    exp_q.push_back(mk(2'd1, 128'h62, 1));
    exp_q.push_back(mk(2'd3, '0, 0));
    run_stream("back_to_back", "<i></i>Hi<B>", 1'b1, 100, 100);
  endtask

  task automatic test_truncate_reset();
    string s = "<di";
    int act = 0;
    do_reset();
    for (int i = 0; i < 19; i++) s = $sformatf("%sv", s);
    s = $sformatf("%s>", s);
    exp_q.delete();
    exp_q.push_back(mk(2'd1, {{14{8'h76}}, 8'h69, 8'h64}, 16));
    run_stream("truncate", s, 1'b0, 100, 100);
    token_ready = 1'b0;
    send_char(8'h3C); send_char(8'h62); send_char(8'h3E);
    n_total++; if (token_valid !== 1'b1) $display("FAIL pre-reset token_valid: got %b, want 1", token_valid); else n_pass++;
    #2 state_enable = 1'b0;
    #1;
    n_total++;
    if (token_valid !== 1'b0 || token_type !== 2'd0 || token_name !== '0 ||
        token_len !== 5'd0 || char_ready !== 1'b0)
      $display("FAIL async reset outputs: got v=%b t=%0d n=%h l=%0d cr=%b, want all 0",
               token_valid, token_type, token_name, token_len, char_ready);
    else n_pass++;
    @(posedge clock); #1;
    state_enable = 1'b1;
    token_ready = 1'b1;
    repeat (6) begin @(posedge clock); #1; if (token_valid) act++; end
    token_ready = 1'b0;
    n_total++; if (act !== 0) $display("FAIL reset no resume: %0d token cycles, want 0", act); else n_pass++;
  endtask

  task automatic test_random();
    string alph = "aZq<>/! =\tXb<>>!";
    string s;
    int n, vp, rp;
    for (int it = 0; it < 40; it++) begin
      do_reset();
      s = "";
      n = $urandom_range(40, 1);
      for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, alph[$urandom_range(alph.len() - 1)]);
      vp = $urandom_range(100, 30);
      rp = $urandom_range(100, 20);
      model(s, 1'b1);
      run_stream($sformatf("random%0d", it), s, 1'b1, vp, rp);
    end
  endtask

  initial begin
    test_reset();
    test_open_latency();
    test_text_close_end();
    test_backpressure();
    test_long_text();
    test_comment_empty();
    test_back_to_back();
    test_truncate_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/html_tokenizer.md
Name: html_tokenizer

Overview:
Consumes the character stream produced by the HTML file reader and splits it into tokens for the downstream layout and render stages. Token types are text runs, opening tags and closing tags, plus a final END marker. Every character is accepted through a valid/ready handshake. Every token is offered through a valid/ready handshake and held stable until it is taken. Tag names are lower-cased and truncated; attributes and comments are discarded.

Parameters:
CHAR_W, 8, bits per character
NAME_MAX, 16, maximum characters per token payload (tag name or text chunk)
LEN_W, 5, width of token_len (must hold NAME_MAX)

Ports:
clock  in  1  system clock, rising edge
state_enable  in  1  asynchronous active-low reset (0 = reset, 1 = run)
char_valid  in  1  char holds a valid character
char  in  CHAR_W  input character
char_ready  out  1  tokenizer accepts char this cycle
input_done  in  1  level; source has no more characters (sampled only when char_valid=0)
token_valid  out  1  token outputs valid
token_ready  in  1  consumer takes token this cycle
token_type  out  2  0=TEXT, 1=OPEN, 2=CLOSE, 3=END
token_name  out  NAME_MAX*CHAR_W  payload; char 0 in LSBs; unused bytes zero
token_len  out  LEN_W  payload length, 0..NAME_MAX

Behaviour:
- Reset (state_enable=0, asynchronous): state=DATA, buffer and length cleared. Outputs: token_valid=0, token_type=0, token_name=0, token_len=0, char_ready=0. char_ready rises the first clock after release.
- A character is accepted on a rising edge when char_valid & char_ready.
- char_ready=1 in DATA, TAG_OPEN, TAG_NAME, ATTR_SKIP and COMMENT. It is 0 in EMIT and DONE, and whenever token_valid=1.
- Emission: token_valid rises on the edge after the terminating character is accepted (1-cycle latency). type/name/len stay frozen until the edge where token_valid & token_ready. Then token_valid falls, the buffer is cleared and the FSM enters the pending next state. char_ready returns the cycle after the handshake.
- DATA:
  - '<' with len>0: emit TEXT, next state TAG_OPEN.
  - '<' with len=0: go to TAG_OPEN directly.
  - Any other char: append it. When len reaches NAME_MAX, emit TEXT immediately (next state DATA). Long text therefore splits into NAME_MAX-sized chunks with no loss.
- TAG_OPEN:
  - '/': set close flag, go to TAG_NAME.
  - '!': go to COMMENT.
  - '>': empty tag, dropped, go to DATA.
  - Any other char: lower-case it (0x41-0x5A + 0x20), append, go to TAG_NAME.
- TAG_NAME:
  - Space, 0x09, 0x0A, 0x0D or '/': go to ATTR_SKIP.
  - '>': emit OPEN, or CLOSE if the close flag is set; next state DATA; close flag cleared.
  - Any other char: lower-case and append while len<NAME_MAX. Once len=NAME_MAX, further chars are dropped and len saturates.
- ATTR_SKIP: discard chars until '>', then emit as in TAG_NAME.
- COMMENT: discard chars until '>', then go to DATA; no token is emitted.
- End of input (input_done=1, char_valid=0, FSM not in EMIT):
  - In DATA with len>0: emit TEXT, then END.
  - Mid-tag or mid-comment: discard the partial tag and emit END only.
  - END token: len=0, name=0.
  - After the END handshake, enter DONE. DONE holds char_ready=0 and token_valid=0 until reset.
- Simultaneous token handshake and char_valid: the char is not accepted that cycle (char_ready=0).
- Reset mid-token: the token is lost, token_valid drops asynchronously, and nothing resumes.

Test Plan:
- Stream "<HTML>" with token_ready=1 → one OPEN token, name "html" (bytes 68 74 6D 6C), len=4, token_valid 1 cycle after '>' is accepted.
- Stream "ab</p>" then input_done → TEXT "ab" len=2, then CLOSE "p" len=1, then END; char_ready stays 0 afterwards.
- Stream "<a href=x>" with token_ready held 0 for 5 cycles → OPEN "a" len=1 held stable for 5 cycles; char_ready=0 throughout; one token only.
- Stream 20 'x' chars then '<' → TEXT len=16, then TEXT len=4, with no chars dropped.
- Stream "<!-- c -->" and "<>" → no tokens; the next char "z" followed by input_done → TEXT "z" then END.
- Stream "<divvvvvvvvvvvvvvvvvv>" (19 'v') → OPEN with len=16; state_enable pulled low mid-tag → all outputs 0 immediately.
